// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state and grant encodings for the instruction/data memory-port arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    MEMARB_IDLE   = 2'd0,
    MEMARB_BUSY_I = 2'd1,
    MEMARB_BUSY_D = 2'd2
  } memarb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, data and memory-controller handshake bundle around mem_bus_arbiter.
// master: the arbiter's view; slave: pipeline stages plus memory controller.
interface mem_bus_arbiter_if;
  logic        i_start;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        d_start;
  logic        d_ready;
  logic [31:0] d_addr;
  logic        d_wen;
  logic [31:0] d_wdata;
  logic [31:0] d_data;
  logic        d_data_valid;
  logic        mem_start;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;
  logic        mem_data_valid;

  modport master (
    input  i_start, i_addr, d_start, d_addr, d_wen, d_wdata,
           mem_ready, mem_data, mem_data_valid,
    output i_ready, i_data, i_data_valid, d_ready, d_data, d_data_valid,
           mem_start, mem_addr, mem_wen, mem_wdata
  );

  modport slave (
    output i_start, i_addr, d_start, d_addr, d_wen, d_wdata,
           mem_ready, mem_data, mem_data_valid,
    input  i_ready, i_data, i_data_valid, d_ready, d_data, d_data_valid,
           mem_start, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// Pure combinational priority picker between fetch (I) and data (D) requesters.
module mem_bus_arbiter_pick (
  input  logic can_issue,
  input  logic i_start,
  input  logic d_start,
  input  logic prio_d,
  output logic i_ready,
  output logic d_ready,
  output logic grant_i,
  output logic grant_d
);

  // The low-priority ready looks at the high-priority start only, never the reverse.
  always_comb begin
    i_ready = can_issue && (!prio_d || !d_start);
    d_ready = can_issue && ( prio_d || !i_start);
    grant_i = i_start && i_ready;
    grant_d = d_start && d_ready;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and data stages, one transaction in flight.
// Define MEMARB_ROUND_ROBIN_EN for alternating priority; default is fixed D-over-I.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_bus_arbiter_if.master bus
);

  memarb_state_e state_q, state_d;
  logic can_issue, prio_d, grant_i, grant_d, i_ready, d_ready, rsp_ok;

  always_comb can_issue = !rst && bus.mem_ready &&
                          (state_q == MEMARB_IDLE || bus.mem_data_valid);

`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_i)      last_grant_d = GRANT_I;
    else if (grant_d) last_grant_d = GRANT_D;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GRANT_D;
    else     last_grant_q <= last_grant_d;
  end

  assign prio_d = (last_grant_q == GRANT_I);
`else
  // Without round-robin the last grant has no observer, so it is not kept.
  assign prio_d = 1'b1;
`endif

  mem_bus_arbiter_pick u_pick (
    .can_issue (can_issue),
    .i_start   (bus.i_start),
    .d_start   (bus.d_start),
    .prio_d    (prio_d),
    .i_ready   (i_ready),
    .d_ready   (d_ready),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  always_comb begin
    state_d = state_q;
    if (grant_i)
      state_d = MEMARB_BUSY_I;
    else if (grant_d)
      state_d = MEMARB_BUSY_D;
    else if (bus.mem_data_valid && state_q != MEMARB_IDLE)
      state_d = MEMARB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEMARB_IDLE;
    else     state_q <= state_d;
  end

  // Responses are gated by rst so nothing leaks while the state register is being cleared.
  always_comb rsp_ok = !rst && bus.mem_data_valid;

  always_comb begin
    bus.i_ready      = i_ready;
    bus.d_ready      = d_ready;
    bus.mem_start    = grant_i || grant_d;
    bus.mem_addr     = '0;
    bus.mem_wen      = 1'b0;
    bus.mem_wdata    = '0;
    if (grant_d) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wen   = bus.d_wen;
      bus.mem_wdata = bus.d_wdata;
    end else if (grant_i) begin
      bus.mem_addr  = bus.i_addr;
    end
    bus.i_data_valid = rsp_ok && (state_q == MEMARB_BUSY_I);
    bus.d_data_valid = rsp_ok && (state_q == MEMARB_BUSY_D);
    bus.i_data       = bus.i_data_valid ? bus.mem_data : '0;
    bus.d_data       = bus.d_data_valid ? bus.mem_data : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an ownership-based reference model.
// Works in both the default and MEMARB_ROUND_ROBIN_EN builds.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory (0 none, 1 fetch, 2 data) and who was served last.
  int   owner      = 0;
  int   owner_nxt  = 0;
  logic last_d     = 1'b1;
  logic last_d_nxt = 1'b1;

  always begin
    logic free, prio_i, ir, dr, gi, gd, rv;
    logic [31:0] addr_e, wdata_e;
    @(negedge clk);
    free = !rst && bus.mem_ready && (owner == 0 || bus.mem_data_valid);
`ifdef MEMARB_ROUND_ROBIN_EN
    prio_i = last_d;
`else
    prio_i = 1'b0;
`endif
    ir = free && (prio_i || !bus.d_start);
    dr = free && (!prio_i || !bus.i_start);
    gi = bus.i_start && ir;
    gd = bus.d_start && dr;
    addr_e  = gd ? bus.d_addr : (gi ? bus.i_addr : 32'h0);
    wdata_e = gd ? bus.d_wdata : 32'h0;
    rv = !rst && bus.mem_data_valid;
    chk("m_i_ready",   bus.i_ready,   ir);
    chk("m_d_ready",   bus.d_ready,   dr);
    chk("m_mem_start", bus.mem_start, gi || gd);
    chk("m_mem_addr",  bus.mem_addr,  addr_e);
    chk("m_mem_wen",   bus.mem_wen,   gd && bus.d_wen);
    chk("m_mem_wdata", bus.mem_wdata, wdata_e);
    chk("m_i_valid",   bus.i_data_valid, rv && owner == 1);
    chk("m_d_valid",   bus.d_data_valid, rv && owner == 2);
    chk("m_i_data",    bus.i_data, (rv && owner == 1) ? bus.mem_data : 32'h0);
    chk("m_d_data",    bus.d_data, (rv && owner == 2) ? bus.mem_data : 32'h0);
    owner_nxt  = owner;
    last_d_nxt = last_d;
    if (rst) begin
      owner_nxt  = 0;
      last_d_nxt = 1'b1;
    end else if (gi) begin
      owner_nxt  = 1;
      last_d_nxt = 1'b0;
    end else if (gd) begin
      owner_nxt  = 2;
      last_d_nxt = 1'b1;
    end else if (bus.mem_data_valid) begin
      owner_nxt  = 0;
    end
    @(posedge clk);
    owner  = owner_nxt;
    last_d = last_d_nxt;
  end

  task automatic set(input logic r, input logic mr,
                     input logic is, input logic [31:0] ia,
                     input logic ds, input logic [31:0] da, input logic dw, input logic [31:0] dwd,
                     input logic mv, input logic [31:0] md);
    rst                = r;
    bus.mem_ready      = mr;
    bus.i_start        = is;
    bus.i_addr         = ia;
    bus.d_start        = ds;
    bus.d_addr         = da;
    bus.d_wen          = dw;
    bus.d_wdata        = dwd;
    bus.mem_data_valid = mv;
    bus.mem_data       = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] alt_addr [4];
`ifdef MEMARB_ROUND_ROBIN_EN
    alt_addr = '{32'h40, 32'h100, 32'h40, 32'h100};
`else
    alt_addr = '{32'h100, 32'h100, 32'h100, 32'h100};
`endif

    // Reset with every input active: everything stays quiet.
    set(1, 1, 1, 32'h10, 1, 32'h20, 1, 32'h30, 1, 32'h55);
    @(negedge clk);
    chk("rst_i_ready", bus.i_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_mem_start", bus.mem_start, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_d_valid", bus.d_data_valid, 0);
    tick();
    tick();

    // Single fetch at 0x0, then its response.
    set(0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("f_mem_start", bus.mem_start, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h0);
    tick();
    set(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h13);
    @(negedge clk);
    chk("f_i_valid", bus.i_data_valid, 1);
    chk("f_i_data", bus.i_data, 32'h13);
    chk("f_d_valid", bus.d_data_valid, 0);
    tick();

    // Simultaneous request after an I grant: D wins in both builds.
    set(0, 1, 1, 32'h40, 1, 32'h100, 1, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    chk("c_d_ready", bus.d_ready, 1);
    chk("c_i_ready", bus.i_ready, 0);
    chk("c_mem_wen", bus.mem_wen, 1);
    chk("c_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    set(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    @(negedge clk);
    chk("c_d_valid", bus.d_data_valid, 1);
    chk("c_i_valid", bus.i_data_valid, 0);
    tick();

    // Repeated contention: alternates only with round-robin enabled.
    for (int i = 0; i < 4; i++) begin
      set(0, 1, 1, 32'h40, 1, 32'h100, 1, 32'hDEADBEEF, 0, 0);
      @(negedge clk);
      chk("alt_mem_addr", bus.mem_addr, alt_addr[i]);
      tick();
      set(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1000 + i);
      tick();
    end

    // Back-to-back fetch at 0x4: response and new issue in the same cycle.
    set(0, 1, 1, 32'h4, 0, 0, 0, 0, 0, 0);
    tick();
    set(0, 1, 1, 32'h4, 0, 0, 0, 0, 1, 32'h77);
    @(negedge clk);
    chk("b2b_i_valid", bus.i_data_valid, 1);
    chk("b2b_i_data", bus.i_data, 32'h77);
    chk("b2b_mem_start", bus.mem_start, 1);
    chk("b2b_mem_addr", bus.mem_addr, 32'h4);
    tick();
    set(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h88);
    @(negedge clk);
    chk("b2b_still_i", bus.i_data_valid, 1);
    tick();

    // Memory not ready while idle, then a stray response in idle.
    set(0, 0, 1, 32'hC, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("nr_i_ready", bus.i_ready, 0);
    chk("nr_mem_start", bus.mem_start, 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
    @(negedge clk);
    chk("idle_i_valid", bus.i_data_valid, 0);
    chk("idle_d_valid", bus.d_data_valid, 0);
    tick();
    set(0, 1, 1, 32'hC, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("nr_then_issue", bus.mem_start, 1);
    tick();
    set(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h11);
    tick();

    // Reset while a data read is outstanding; late response is discarded.
    set(0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_mem_wen", bus.mem_wen, 0);
    tick();
    set(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set(0, 1, 1, 32'h8, 0, 0, 0, 0, 1, 32'h99);
    @(negedge clk);
    chk("mid_d_valid", bus.d_data_valid, 0);
    chk("mid_i_valid", bus.i_data_valid, 0);
    chk("mid_mem_start", bus.mem_start, 1);
    chk("mid_mem_addr", bus.mem_addr, 32'h8);
    tick();
    set(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'hAA);
    @(negedge clk);
    chk("mid_i_done", bus.i_data_valid, 1);
    tick();
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
